rx_cmd_ctrl: RTL and testbench
==============================

# rx_cmd_ctrl

Receive-side command controller for the UART vector coprocessor, the counterpart of `txCtrl`. It consumes bytes from the UART receiver, decodes a one-byte opcode, streams vector payloads into the A/B vector memories, and issues one-hot operation requests. Its `enables` output feeds the datapath and `txCtrl`, so the operation selected on receive is the one whose 32-bit result is later sent back.

## Interface
Parameters:
- `N_ELEMENTS`, 1024: elements per vector, one byte each.
- `ADDR_W`, 10: memory address width; must satisfy 2^ADDR_W ≥ N_ELEMENTS.
- `RX_TIMEOUT`, 1_000_000: maximum idle cycles between payload bytes; used only with `RX_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only while `rx_ready`=1.
- `rx_ready`  in  1  one-cycle strobe per received byte.
- `op_busy`  in  1  datapath or `txCtrl` still working; high means no new operation may start.
- `wr_en_a`  out  1  one-cycle write strobe for vector A memory.
- `wr_en_b`  out  1  one-cycle write strobe for vector B memory.
- `wr_addr`  out  ADDR_W  element index for the current write.
- `wr_data`  out  8  element value for the current write.
- `load_done`  out  1  one-cycle pulse when the last element of a vector has been written.
- `enables`  out  6  one-hot operation select; bit5 dot, bit4 man, bit1 sum, other bits per the coprocessor op map. Held stable between issues.
- `op_start`  out  1  one-cycle pulse that launches the selected operation.
- `cmd_error`  out  1  one-cycle pulse on an illegal opcode, a rejected command, or a timeout.

## Operation
- States: IDLE and LOAD. LOAD records the target vector (A or B).
- While in IDLE, each `rx_ready` byte is an opcode:
  - 0x01: enter LOAD targeting vector A, with the element counter at 0.
  - 0x02: enter LOAD targeting vector B, with the element counter at 0.
  - 0x03–0x08: set `enables` to one-hot bit (opcode−3) and pulse `op_start`. The state stays IDLE.
  - Any other value: pulse `cmd_error`; all outputs other than the pulse are unchanged.
- Any opcode received while `op_busy`=1 is rejected with a `cmd_error` pulse. This includes load opcodes, so memory is not overwritten during an operation. `enables` is not changed.
- While in LOAD, each `rx_ready` byte:
  - writes to the target vector at `wr_addr` = counter, then increments the counter;
  - on the byte with counter = N_ELEMENTS−1, also pulses `load_done` and returns to IDLE.
- Addresses run 0..N_ELEMENTS−1 with no wrap. A new load always restarts at 0.
- Bytes arriving in LOAD are never decoded as opcodes.

## Timing
- Reset values are all 0: `wr_en_a`, `wr_en_b`, `wr_addr`, `wr_data`, `load_done`, `enables`, `op_start`, `cmd_error`, the counter, and the timeout counter. The state resets to IDLE.
- All outputs are registered, with 1-cycle latency. A `rx_ready` at edge t produces the write, `load_done`, `op_start`, `enables` update or `cmd_error` at edge t+1.
- `wr_addr` and `wr_data` are valid only while a write strobe is high. They hold their last value otherwise.
- Back-to-back `rx_ready` on consecutive cycles must be accepted without loss.
- `op_busy` is sampled in the same cycle as the opcode's `rx_ready`.
- Reset asserted mid-LOAD:
  - the load is discarded and the state returns to IDLE;
  - the first byte after reset is decoded as an opcode;
  - memory contents already written are not touched.

## Configuration
- `RX_TIMEOUT_EN` defined:
  - in LOAD, a counter clears on every `rx_ready` and increments otherwise;
  - when it reaches RX_TIMEOUT−1, the block pulses `cmd_error` and returns to IDLE;
  - elements already written remain in memory, and no `load_done` is issued;
  - if `rx_ready` arrives in the same cycle the count expires, the byte wins and no timeout occurs.
- `RX_TIMEOUT_EN` undefined: no timeout counter exists, and LOAD waits indefinitely.

## Test plan
All scenarios use N_ELEMENTS=4, ADDR_W=2, RX_TIMEOUT=20.
- Send 0x01, 0x11, 0x22, 0x33, 0x44 back-to-back → `wr_en_a` pulses four times with addr 0..3 and data 0x11..0x44; `load_done` rises in the same cycle as the fourth write; `wr_en_b` never rises.
- Send 0x08 with `op_busy`=0 → `enables`=6'b100000 and one `op_start` pulse one cycle later. Then send 0x04 → `enables`=6'b000010.
- Send 0x07 with `op_busy`=1 → `cmd_error` pulses, no `op_start`, `enables` unchanged. Send 0xFF with `op_busy`=0 → `cmd_error` pulses.
- Send 0x02, then two bytes, then idle 25 cycles (`RX_TIMEOUT_EN` defined) → two `wr_en_b` writes, `cmd_error` pulses, no `load_done`. A following 0x05 is decoded as an opcode: `enables`=6'b000100.
- Send 0x01 and one byte, assert `reset`=0 for 2 cycles, release, then send 0x03 → all outputs 0 during reset; afterwards `op_start` pulses and `enables`=6'b000001.

Source files
------------

// File: rtl/rx_cmd_ctrl.sv
// Receive-side command controller: decodes UART opcodes, streams vector payloads
// into the A/B memories and issues one-hot operation requests. Optional macro: RX_TIMEOUT_EN.
module rx_cmd_ctrl #(
  parameter int N_ELEMENTS = 1024,
  parameter int ADDR_W     = 10,
  parameter int RX_TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              op_busy,
  output logic              wr_en_a,
  output logic              wr_en_b,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              load_done,
  output logic [5:0]        enables,
  output logic              op_start,
  output logic              cmd_error
);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic              target_b_reg, target_b_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  logic              wr_en_a_reg, wr_en_a_next;
  logic              wr_en_b_reg, wr_en_b_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]        wr_data_reg, wr_data_next;
  logic              load_done_reg, load_done_next;
  logic [5:0]        enables_reg, enables_next;
  logic              op_start_reg, op_start_next;
  logic              cmd_error_reg, cmd_error_next;

  logic       is_load_op;
  logic       is_exec_op;
  logic       last_elem;
  logic       timeout;
  logic [2:0] op_idx;

  assign is_load_op = (rx_data == 8'h01) || (rx_data == 8'h02);
  assign is_exec_op = (rx_data >= 8'h03) && (rx_data <= 8'h08);
  assign last_elem  = (cnt_reg == ADDR_W'(N_ELEMENTS - 1));
  // Opcodes 3..8 map onto bits 0..5; the 3-bit subtraction wraps 8 onto 5.
  assign op_idx     = rx_data[2:0] - 3'd3;

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = $clog2(RX_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_reg;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout = (state_reg == LOAD) && !rx_ready && (to_cnt_reg == TO_W'(RX_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      to_cnt_reg <= '0;
    else if ((state_reg != LOAD) || rx_ready)
      to_cnt_reg <= '0;
    else
      to_cnt_reg <= to_cnt_reg + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      target_b_reg  <= 1'b0;
      cnt_reg       <= '0;
      wr_en_a_reg   <= 1'b0;
      wr_en_b_reg   <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      load_done_reg <= 1'b0;
      enables_reg   <= '0;
      op_start_reg  <= 1'b0;
      cmd_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      target_b_reg  <= target_b_next;
      cnt_reg       <= cnt_next;
      wr_en_a_reg   <= wr_en_a_next;
      wr_en_b_reg   <= wr_en_b_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      load_done_reg <= load_done_next;
      enables_reg   <= enables_next;
      op_start_reg  <= op_start_next;
      cmd_error_reg <= cmd_error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    target_b_next = target_b_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (rx_ready && !op_busy && is_load_op) begin
          state_next    = LOAD;
          target_b_next = (rx_data == 8'h02);
          cnt_next      = '0;
        end
      end
      LOAD: begin
        if (rx_ready) begin
          cnt_next = cnt_reg + 1'b1;
          if (last_elem) begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else if (timeout) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_en_a_next   = 1'b0;
    wr_en_b_next   = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    load_done_next = 1'b0;
    enables_next   = enables_reg;
    op_start_next  = 1'b0;
    cmd_error_next = timeout;
    if (rx_ready) begin
      case (state_reg)
        IDLE: begin
          if (op_busy || !(is_load_op || is_exec_op)) begin
            cmd_error_next = 1'b1;
          end else if (is_exec_op) begin
            enables_next  = 6'd1 << op_idx;
            op_start_next = 1'b1;
          end
        end
        LOAD: begin
          wr_en_a_next   = !target_b_reg;
          wr_en_b_next   = target_b_reg;
          wr_addr_next   = cnt_reg;
          wr_data_next   = rx_data;
          load_done_next = last_elem;
        end
        default: ;
      endcase
    end
  end

  assign wr_en_a   = wr_en_a_reg;
  assign wr_en_b   = wr_en_b_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign load_done = load_done_reg;
  assign enables   = enables_reg;
  assign op_start  = op_start_reg;
  assign cmd_error = cmd_error_reg;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Directed bench for rx_cmd_ctrl with N_ELEMENTS=4, ADDR_W=2, RX_TIMEOUT=20.
// Follows the RX_TIMEOUT_EN build choice of the design.
module tb_rx_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       op_busy;
  logic       wr_en_a, wr_en_b, load_done, op_start, cmd_error;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] enables;

  int checks = 0;
  int errors = 0;

  rx_cmd_ctrl #(.N_ELEMENTS(4), .ADDR_W(2), .RX_TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready), .op_busy(op_busy),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_done(load_done), .enables(enables), .op_start(op_start), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b, input logic busy);
    rx_data  = b;
    rx_ready = 1'b1;
    op_busy  = busy;
    tick();
  endtask

  task automatic idle();
    rx_ready = 1'b0;
    op_busy  = 1'b0;
    tick();
  endtask

  // Packed strobes: {wr_en_a, wr_en_b, load_done, op_start, cmd_error}
  function automatic logic [4:0] strobes();
    return {wr_en_a, wr_en_b, load_done, op_start, cmd_error};
  endfunction

  initial begin
    int err_cnt;
    int done_cnt;
    int wrb_cnt;
    logic [7:0] vec_a [4];
    vec_a[0] = 8'h11; vec_a[1] = 8'h22; vec_a[2] = 8'h33; vec_a[3] = 8'h44;

    reset = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; op_busy = 1'b0;
    tick(); tick();
    check("reset_strobes", 32'(strobes()), 32'h0);
    check("reset_enables", 32'(enables), 32'h0);
    check("reset_addr_data", {22'h0, wr_addr, wr_data}, 32'h0);
    reset = 1'b1;
    tick();

    // Load vector A back-to-back
    drive(8'h01, 1'b0);
    check("load_a_opcode_no_write", 32'(strobes()), 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(vec_a[i], 1'b0);
      check($sformatf("load_a_strobes[%0d]", i), 32'(strobes()), (i == 3) ? 32'b10100 : 32'b10000);
      check($sformatf("load_a_addr_data[%0d]", i), {22'h0, wr_addr, wr_data}, {22'h0, 2'(i), vec_a[i]});
    end
    idle();
    check("load_a_after_strobes", 32'(strobes()), 32'h0);
    check("load_a_addr_hold", {22'h0, wr_addr, wr_data}, {22'h0, 2'd3, 8'h44});

    // Operation issue
    drive(8'h08, 1'b0);
    check("op08_enables", 32'(enables), 32'b100000);
    check("op08_strobes", 32'(strobes()), 32'b00010);
    idle();
    check("op08_start_one_cycle", 32'(strobes()), 32'h0);
    drive(8'h04, 1'b0);
    check("op04_enables", 32'(enables), 32'b000010);
    check("op04_strobes", 32'(strobes()), 32'b00010);
    idle();

    // Busy rejection and illegal opcode
    drive(8'h07, 1'b1);
    check("busy07_strobes", 32'(strobes()), 32'b00001);
    check("busy07_enables", 32'(enables), 32'b000010);
    idle();
    check("busy07_err_one_cycle", 32'(strobes()), 32'h0);
    drive(8'hFF, 1'b0);
    check("illegal_ff_strobes", 32'(strobes()), 32'b00001);
    check("illegal_ff_enables", 32'(enables), 32'b000010);
    drive(8'h01, 1'b1);
    check("busy_load_rejected", 32'(strobes()), 32'b00001);
    drive(8'h06, 1'b0);
    check("after_busy_load_op06", 32'(strobes()), 32'b00010);
    check("after_busy_load_enables", 32'(enables), 32'b001000);
    idle();

    // Load vector B, two bytes, then a long gap
    drive(8'h02, 1'b0);
    drive(8'h55, 1'b0);
    check("load_b_w0", {27'h0, strobes()}, 32'b01000);
    check("load_b_w0_addr_data", {22'h0, wr_addr, wr_data}, {22'h0, 2'd0, 8'h55});
    drive(8'h66, 1'b0);
    check("load_b_w1", {27'h0, strobes()}, 32'b01000);
    check("load_b_w1_addr_data", {22'h0, wr_addr, wr_data}, {22'h0, 2'd1, 8'h66});
    err_cnt = 0; done_cnt = 0; wrb_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      idle();
      err_cnt  += int'(cmd_error);
      done_cnt += int'(load_done);
      wrb_cnt  += int'(wr_en_b);
    end
    check("gap_no_load_done", 32'(done_cnt), 32'd0);
    check("gap_no_write", 32'(wrb_cnt), 32'd0);
`ifdef RX_TIMEOUT_EN
    check("timeout_err_pulses", 32'(err_cnt), 32'd1);
`else
    check("no_timeout_err", 32'(err_cnt), 32'd0);
    drive(8'h77, 1'b0);
    check("load_b_w2", {22'h0, wr_addr, wr_data}, {22'h0, 2'd2, 8'h77});
    drive(8'h88, 1'b0);
    check("load_b_w3_strobes", 32'(strobes()), 32'b01100);
    check("load_b_w3", {22'h0, wr_addr, wr_data}, {22'h0, 2'd3, 8'h88});
    idle();
`endif
    drive(8'h05, 1'b0);
    check("op05_strobes", 32'(strobes()), 32'b00010);
    check("op05_enables", 32'(enables), 32'b000100);
    idle();

    // Reset in the middle of a load
    drive(8'h01, 1'b0);
    drive(8'hAA, 1'b0);
    check("pre_reset_write", 32'(strobes()), 32'b10000);
    rx_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_reset_strobes", 32'(strobes()), 32'h0);
    check("mid_reset_enables", 32'(enables), 32'h0);
    check("mid_reset_addr_data", {22'h0, wr_addr, wr_data}, 32'h0);
    tick(); tick();
    check("reset_held_strobes", 32'(strobes()), 32'h0);
    reset = 1'b1;
    tick();
    drive(8'h03, 1'b0);
    check("post_reset_op03_strobes", 32'(strobes()), 32'b00010);
    check("post_reset_op03_enables", 32'(enables), 32'b000001);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
